program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Parametrised successor to the bench-driven program load path (mode/address/data into RAM).
//  Loads a program image into program RAM through a valid/ready stream, then releases the CPU.
//  Optional memory-clear pass, explicit or auto-increment addressing, checksum and overrun error.
//  Sits between the host/test stimulus and the RAM write port; drives the CPU run enable.
// PARAMETERS
//  ADDR_W    4  RAM address width; DEPTH = 2**ADDR_W words
//  DATA_W    8  RAM word width (opcode+operand)
//  CLEAR_EN  1  1: zero every RAM word before loading; 0: skip the clear pass
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  reset       in   1       asynchronous, active-low reset
//  load_start  in   1       pulse: begin a new load (accepted in IDLE or RUN)
//  auto_inc    in   1       sampled at load_start: 1 = ignore in_addr, use internal counter from 0
//  in_valid    in   1       stream word valid
//  in_ready    out  1       loader accepts the word this cycle
//  in_addr     in   ADDR_W  word address (explicit mode only)
//  in_data     in   DATA_W  word to store
//  in_last     in   1       final word of the image
//  mem_we      out  1       RAM write strobe
//  mem_addr    out  ADDR_W  RAM write address
//  mem_wdata   out  DATA_W  RAM write data
//  cpu_run     out  1       1 = CPU may fetch/execute; 0 = CPU held in reset
//  busy        out  1       high in CLEAR or LOAD
//  done        out  1       one-cycle pulse on entry to RUN
//  err         out  1       sticky overrun error, cleared by load_start
//  word_count  out  ADDR_W+1 words accepted in current load
//  checksum    out  DATA_W  sum of accepted in_data, modulo 2**DATA_W
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (in_ready, mem_we, cpu_run, busy, done, err, count, checksum).
//  States: IDLE -> (load_start) CLEAR if CLEAR_EN else LOAD; CLEAR -> LOAD after DEPTH writes;
//   LOAD -> RUN on accepted word with in_last; RUN -> (load_start) CLEAR/LOAD as from IDLE.
//  load_start: clears word_count, checksum, err, address counter; latches auto_inc; drops cpu_run
//   the same edge. Ignored while busy.
//  CLEAR: one write/cycle, mem_addr 0..DEPTH-1, mem_wdata 0; exactly DEPTH cycles; in_ready=0.
//  LOAD: in_ready=1; handshake = in_valid & in_ready. Accepted word -> registered mem_we next
//   cycle (latency 1) with mem_addr = in_addr (explicit) or counter (auto_inc); counter +1.
//  Auto-inc overrun: word accepted when counter has already wrapped (word_count == DEPTH) ->
//   write suppressed, err=1, word still counted/checksummed; load continues to in_last.
//  Explicit mode: no overrun check; later write to same address overwrites earlier one.
//  word_count saturates at 2**(ADDR_W+1)-1; checksum wraps modulo 2**DATA_W.
//  RUN: cpu_run=1 from the cycle after the last write is issued; in_ready=0; done pulses once.
//  in_valid outside LOAD: ignored, no write, no count.
//  Reset asserted mid-CLEAR/LOAD: immediate return to IDLE, mem_we deasserted, cpu_run 0;
//   RAM contents left as partially written.
// STRUCTURE
//  loader_pkg: typedef enum {LD_IDLE, LD_CLEAR, LD_LOAD, LD_RUN} loader_state_t; DEPTH helper.
//  Single module; no sub-module. Address counter shared by CLEAR and auto-inc LOAD.
//  Integrates with existing RAM write port in place of input_mode/input_address/input_program.
// TESTING
//  T1 reset: reset=0 mid-run -> all outputs 0, state IDLE; release -> stays IDLE, no writes.
//  T2 CLEAR_EN=1, auto_inc=1, load 03,05,79,30,9A(last) -> 16 zero writes, then addr 0..4,
//   word_count=5, checksum=0x4B, done pulse, cpu_run=1.
//  T3 explicit: (9,03),(A,05),(0,79),(1,30),(2,9A,last) -> writes at those addresses in order;
//   with the SAP core attached, B=7 after OR B,[A].
//  T4 backpressure: in_valid toggled randomly, words held stable -> no loss/duplication,
//   one mem_we per accepted word, latency exactly 1 cycle.
//  T5 overrun: auto_inc, 17 words -> 16 writes, err=1 after 17th, word_count=17.
//  T6 reload: load_start in RUN -> cpu_run drops same edge, err/count/checksum cleared,
//   new image loaded; load_start while busy ignored.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared state encoding and sizing helper for the program loader.
package loader_pkg;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_CLEAR,
        LD_LOAD,
        LD_RUN
    } loader_state_t;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Streams a program image into RAM (optionally after a zero-fill pass), then releases the CPU.
// Tracks accepted words, a running checksum and a sticky auto-increment overrun error.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic                auto_inc,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                cpu_run,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     word_count,
    output logic [DATA_W-1:0]   checksum,
    output loader_state_t       dbg_state
);

    localparam int unsigned     DEPTH     = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_MAX   = '1;
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    loader_state_t     state_q;
    loader_state_t     start_state;
    logic              auto_q;
    logic              mem_we_q;
    logic              cpu_run_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_cnt_q;
    logic [ADDR_W-1:0] addr_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] checksum_q;
    logic [DATA_W-1:0] checksum_d;
    logic [ADDR_W:0]   word_count_q;
    logic [ADDR_W:0]   word_count_d;
    logic              accept;
    logic              overrun;

    // Stream handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready is high for the whole LOAD state and never depends on in_valid.
    assign in_ready = (state_q == LD_LOAD);
    assign accept   = in_ready && in_valid;

    assign start_state  = CLEAR_EN ? LD_CLEAR : LD_LOAD;
    assign addr_cnt_d   = addr_cnt_q + ADDR_ONE;
    assign checksum_d   = checksum_q + in_data;
    assign word_count_d = (word_count_q == CNT_MAX) ? word_count_q : word_count_q + CNT_ONE;
    // Once DEPTH words have landed the auto counter has wrapped; further words would clobber them.
    assign overrun      = auto_q && (word_count_q >= CNT_DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LD_IDLE;
            auto_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_run_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            addr_cnt_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            checksum_q   <= '0;
            word_count_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                LD_IDLE, LD_RUN: begin
                    if (load_start) begin
                        state_q      <= start_state;
                        auto_q       <= auto_inc;
                        addr_cnt_q   <= '0;
                        word_count_q <= '0;
                        checksum_q   <= '0;
                        err_q        <= 1'b0;
                        cpu_run_q    <= 1'b0;
                    end else if (state_q == LD_RUN) begin
                        cpu_run_q <= 1'b1;
                    end
                end
                LD_CLEAR: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= addr_cnt_q;
                    mem_wdata_q <= '0;
                    addr_cnt_q  <= addr_cnt_d;
                    if (addr_cnt_q == ADDR_LAST) begin
                        state_q <= LD_LOAD;
                    end
                end
                LD_LOAD: begin
                    if (accept) begin
                        word_count_q <= word_count_d;
                        checksum_q   <= checksum_d;
                        addr_cnt_q   <= addr_cnt_d;
                        if (overrun) begin
                            err_q <= 1'b1;
                        end else begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= auto_q ? addr_cnt_q : in_addr;
                            mem_wdata_q <= in_data;
                        end
                        if (in_last) begin
                            state_q <= LD_RUN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= LD_IDLE;
            endcase
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_run    = cpu_run_q;
    assign busy       = (state_q == LD_CLEAR) || (state_q == LD_LOAD);
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven image loads plus randomized loads scored against a
// word-level model of the load rules, with hand-written reset and busy-restart sequences.
module tb_program_loader;
    import loader_pkg::*;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam bit CLEAR_EN = 1'b1;
    localparam int CNT_MAX  = 31;

    logic                clk;
    logic                reset;
    logic                load_start;
    logic                auto_inc;
    logic                in_valid;
    logic                in_ready;
    logic [ADDR_W-1:0]   in_addr;
    logic [DATA_W-1:0]   in_data;
    logic                in_last;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                cpu_run;
    logic                busy;
    logic                done;
    logic                err;
    logic [ADDR_W:0]     word_count;
    logic [DATA_W-1:0]   checksum;
    loader_state_t       dbg_state;

    program_loader #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .CLEAR_EN(CLEAR_EN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_start(load_start),
        .auto_inc  (auto_inc),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .word_count(word_count),
        .checksum  (checksum),
        .dbg_state (dbg_state)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard: expected {addr,data} writes and the cycle each must appear in
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int                       exp_cyc_q[$];
    logic [ADDR_W+DATA_W-1:0] mon_e;
    int                       mon_c;

    always @(negedge clk) begin
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_write: got no write expected %0h at cycle %0d", exp_q[0], exp_cyc_q[0]);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write (cycle %0d)",
                         mem_addr, mem_wdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("write_addr_data", {mem_addr, mem_wdata}, mon_e);
                check("write_cycle", cyc, mon_c);
            end
        end
    end

    // Image to load, and optional per-word expected write address from a table
    logic [ADDR_W-1:0] img_addr[$];
    logic [DATA_W-1:0] img_data[$];
    logic [ADDR_W-1:0] img_exp[$];

    task automatic make_image(input int n);
        img_addr.delete();
        img_data.delete();
        img_exp.delete();
        for (int i = 0; i < n; i++) begin
            img_addr.push_back(ADDR_W'($urandom));
            img_data.push_back(DATA_W'($urandom));
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_run"}, cpu_run, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_checksum"}, checksum, 0);
        check({tag, "_state"}, dbg_state, LD_IDLE);
    endtask

    // Driver + reference model for one complete load; entered and left on a negedge.
    // poke=1 pulses load_start while busy, which must be ignored.
    task automatic do_load(input bit ai, input int max_gap, input bit poke);
        int                n;
        int                k;
        int                cnt;
        logic [DATA_W-1:0] sum;
        bit                e_err;
        logic [ADDR_W-1:0] wa;
        n     = img_data.size();
        cnt   = 0;
        sum   = '0;
        e_err = 1'b0;
        k     = cyc;
        load_start = 1'b1;
        auto_inc   = ai;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        if (CLEAR_EN) begin
            for (int j = 0; j < DEPTH; j++) begin
                exp_q.push_back({ADDR_W'(j), DATA_W'(0)});
                exp_cyc_q.push_back(k + 2 + j);
            end
        end
        @(negedge clk);
        load_start = 1'b0;
        auto_inc   = ~ai;
        check("start_cpu_run", cpu_run, 0);
        check("start_err", err, 0);
        check("start_word_count", word_count, 0);
        check("start_checksum", checksum, 0);
        check("start_busy", busy, 1);
        if (CLEAR_EN) begin
            for (int j = 0; j < DEPTH; j++) begin
                check("clear_in_ready", in_ready, 0);
                check("clear_busy", busy, 1);
                in_valid   = 1'b1;
                in_addr    = ADDR_W'($urandom);
                in_data    = DATA_W'($urandom);
                in_last    = 1'($urandom_range(0, 1));
                load_start = poke && (j == 5);
                @(negedge clk);
            end
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_addr  = img_addr[i];
            in_data  = img_data[i];
            in_valid = 1'b0;
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            check("load_in_ready", in_ready, 1);
            in_valid   = 1'b1;
            in_last    = (i == n - 1);
            load_start = poke && (i == 1);
            if (ai && i >= DEPTH) begin
                e_err = 1'b1;
            end else begin
                if (img_exp.size() > i) wa = img_exp[i];
                else                    wa = ai ? ADDR_W'(i % DEPTH) : img_addr[i];
                exp_q.push_back({wa, img_data[i]});
                exp_cyc_q.push_back(cyc + 1);
            end
            if (cnt < CNT_MAX) cnt++;
            sum = sum + img_data[i];
            @(negedge clk);
            in_valid   = 1'b0;
            in_last    = 1'b0;
            load_start = 1'b0;
            check("load_word_count", word_count, cnt);
            check("load_checksum", checksum, sum);
            check("load_err", err, e_err);
        end
        check("end_done", done, 1);
        check("end_cpu_run_low", cpu_run, 0);
        check("end_busy", busy, 0);
        check("end_in_ready", in_ready, 0);
        check("end_state", dbg_state, LD_RUN);
        @(negedge clk);
        check("run_done_low", done, 0);
        check("run_cpu_run", cpu_run, 1);
        check("run_word_count", word_count, cnt);
        check("run_checksum", checksum, sum);
        check("run_err", err, e_err);
        check("run_sb_drained", exp_q.size(), 0);
    endtask

    // Reset asserted between clock edges; outputs must drop without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check_quiet(tag);
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        check_quiet(tag);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = DATA_W'($urandom);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check_quiet({tag, "_post"});
    endtask

    typedef struct {
        logic [ADDR_W-1:0] in_addr;
        logic [DATA_W-1:0] in_data;
        logic [ADDR_W-1:0] exp_auto;
        logic [ADDR_W-1:0] exp_expl;
    } vec_t;

    vec_t tab[5];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{4'h9, 8'h03, 4'h0, 4'h9};
        tab[1] = '{4'hA, 8'h05, 4'h1, 4'hA};
        tab[2] = '{4'h0, 8'h79, 4'h2, 4'h0};
        tab[3] = '{4'h1, 8'h30, 4'h3, 4'h1};
        tab[4] = '{4'h2, 8'h9A, 4'h4, 4'h2};

        reset = 1'b0; load_start = 1'b0; auto_inc = 1'b0; in_valid = 1'b0;
        in_addr = '0; in_data = '0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        reset = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check_quiet("idle_valid");

        // Fixed image, auto-increment then explicit addressing
        for (int mode = 1; mode >= 0; mode--) begin
            img_addr.delete(); img_data.delete(); img_exp.delete();
            for (int i = 0; i < 5; i++) begin
                img_addr.push_back(tab[i].in_addr);
                img_data.push_back(tab[i].in_data);
                img_exp.push_back(mode == 1 ? tab[i].exp_auto : tab[i].exp_expl);
            end
            do_load(1'(mode), 0, 1'b0);
            check("tab_word_count", word_count, 5);
            check("tab_checksum", checksum, 8'h4B);
        end

        // Random images with random valid gaps
        for (int r = 0; r < 4; r++) begin
            make_image($urandom_range(3, 14));
            do_load(1'($urandom_range(0, 1)), 3, 1'b0);
        end

        // Auto-increment overrun: 17th word dropped, error raised
        make_image(17);
        do_load(1'b1, 1, 1'b0);
        check("overrun_err", err, 1);
        check("overrun_count", word_count, 17);

        // Reload from RUN with ignored load_start while busy; 33 words saturate the count
        make_image(33);
        do_load(1'b0, 1, 1'b1);
        check("sat_word_count", word_count, CNT_MAX);

        // Reset while running
        async_reset("rst_run");

        // Reset mid-clear: only the first three zero writes may appear
        begin
            int k;
            k = cyc;
            load_start = 1'b1;
            auto_inc   = 1'b1;
            for (int j = 0; j < 3; j++) begin
                exp_q.push_back({ADDR_W'(j), DATA_W'(0)});
                exp_cyc_q.push_back(k + 2 + j);
            end
            @(negedge clk);
            load_start = 1'b0;
            repeat (3) @(negedge clk);
            check("midclear_busy", busy, 1);
            async_reset("rst_clear");
        end

        // A fresh load still works after the interrupted one
        make_image(6);
        do_load(1'b1, 2, 1'b0);

        repeat (2) @(negedge clk);
        check("final_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
